// File: rtl/ula_pkg.sv
// Shared constants for the ALU sequencer: opcode map, data width and
// the sequencer state encoding.
package ula_pkg;

    localparam int LARGURA = 8;

    localparam logic [3:0] OP_SOMA        = 4'd0;
    localparam logic [3:0] OP_SUB         = 4'd1;
    localparam logic [3:0] OP_IGUAL       = 4'd2;
    localparam logic [3:0] OP_DIFERENTE   = 4'd3;
    localparam logic [3:0] OP_MAIOR       = 4'd4;
    localparam logic [3:0] OP_MENOR       = 4'd5;
    localparam logic [3:0] OP_MAIOR_IGUAL = 4'd6;
    localparam logic [3:0] OP_NOT         = 4'd7;
    localparam logic [3:0] OP_AND         = 4'd8;
    localparam logic [3:0] OP_OR          = 4'd9;
    localparam logic [3:0] OP_XOR         = 4'd10;
    localparam logic [3:0] OP_XNOR        = 4'd11;
    localparam logic [3:0] OP_LOAD        = 4'd12;

    typedef enum logic [1:0] {
        OCIOSO  = 2'd0,
        EXECUTA = 2'd1,
        ESCREVE = 2'd2
    } estado_t;

    // What the ESCREVE cycle has to do with the pending command.
    typedef enum logic [1:0] {
        TIPO_ULA  = 2'd0,
        TIPO_LOAD = 2'd1,
        TIPO_ERRO = 2'd2
    } tipo_t;

endpackage

// File: rtl/banco_registradores.sv
// Small general-purpose register bank: two combinational operand reads,
// one combinational debug read and one synchronous write port.
module banco_registradores
    import ula_pkg::*;
#(
    parameter int NUM_REGS = 4,
    parameter int END_W    = 2
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic [END_W-1:0]   end_a,
    input  logic [END_W-1:0]   end_b,
    input  logic [END_W-1:0]   end_leitura,
    input  logic               escrita_en,
    input  logic [END_W-1:0]   end_escrita,
    input  logic [LARGURA-1:0] dados_escrita,
    output logic [LARGURA-1:0] dados_a,
    output logic [LARGURA-1:0] dados_b,
    output logic [LARGURA-1:0] dados_leitura
);

    logic [LARGURA-1:0] regs [NUM_REGS];

    // NOTE: the bank is only a handful of flops, so it is cleared on reset like
    // any other state; a large RAM-style array would normally be left unreset.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
        end else if (escrita_en) begin
            regs[end_escrita] <= dados_escrita;
        end
    end

    assign dados_a       = regs[end_a];
    assign dados_b       = regs[end_b];
    assign dados_leitura = regs[end_leitura];

endmodule

// File: rtl/ula_sequenciador.sv
// Command sequencer in front of the 8-bit ALU: reads operands from the bank,
// drives the ALU, then writes the registered ALU result back one cycle later.
module ula_sequenciador
    import ula_pkg::*;
#(
    parameter int NUM_REGS = 4,
    parameter int END_W    = 2
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic [3:0]         cmd_opCode,
    input  logic [END_W-1:0]   cmd_fonteA,
    input  logic [END_W-1:0]   cmd_fonteB,
    input  logic [END_W-1:0]   cmd_destino,
    input  logic [LARGURA-1:0] cmd_imediato,
    output logic [LARGURA-1:0] entradaA8Bits,
    output logic [LARGURA-1:0] entradaB8Bits,
    output logic [3:0]         opCode,
    input  logic [LARGURA:0]   saida9Bits,
    output logic               res_valid,
    output logic [LARGURA:0]   res_dados,
    output logic               res_erro,
    output logic               flag_carry,
    input  logic [END_W-1:0]   leitura_end,
    output logic [LARGURA-1:0] leitura_dados
);

    estado_t            estado, prox_estado;
    tipo_t              tipo;
    logic [END_W-1:0]   destino;
    logic [LARGURA-1:0] imediato;
    logic               aceita;
    logic               finaliza;
    logic               escrita_en;
    logic [LARGURA-1:0] dados_escrita;
    logic [LARGURA-1:0] dados_a, dados_b;

    banco_registradores #(
        .NUM_REGS (NUM_REGS),
        .END_W    (END_W)
    ) u_banco (
        .clock         (clock),
        .reset_n       (reset_n),
        .end_a         (cmd_fonteA),
        .end_b         (cmd_fonteB),
        .end_leitura   (leitura_end),
        .escrita_en    (escrita_en),
        .end_escrita   (destino),
        .dados_escrita (dados_escrita),
        .dados_a       (dados_a),
        .dados_b       (dados_b),
        .dados_leitura (leitura_dados)
    );

    assign cmd_ready = (estado == OCIOSO);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            estado <= OCIOSO;
        end else begin
            estado <= prox_estado;
        end
    end

    // NOTE: every signal driven here gets a default first, so no branch can
    // leave one unassigned and infer a latch.
    always_comb begin
        prox_estado = estado;
        aceita      = 1'b0;
        finaliza    = 1'b0;
        unique case (estado)
            OCIOSO: begin
                if (cmd_valid) begin
                    aceita      = 1'b1;
                    prox_estado = (cmd_opCode <= OP_XNOR) ? EXECUTA : ESCREVE;
                end
            end
            EXECUTA: prox_estado = ESCREVE;
            ESCREVE: begin
                finaliza    = 1'b1;
                prox_estado = OCIOSO;
            end
            default: prox_estado = OCIOSO;
        endcase
    end

    assign escrita_en    = finaliza && (tipo != TIPO_ERRO);
    assign dados_escrita = (tipo == TIPO_LOAD) ? imediato : saida9Bits[LARGURA-1:0];

    // NOTE: clocked state is assigned with <= only, so every flop samples the
    // values from before the edge regardless of statement order.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            tipo          <= TIPO_ULA;
            destino       <= '0;
            imediato      <= '0;
            entradaA8Bits <= '0;
            entradaB8Bits <= '0;
            opCode        <= '0;
            res_valid     <= 1'b0;
            res_dados     <= '0;
            res_erro      <= 1'b0;
            flag_carry    <= 1'b0;
        end else begin
            res_valid <= finaliza;
            if (aceita) begin
                destino  <= cmd_destino;
                imediato <= cmd_imediato;
                if (cmd_opCode <= OP_XNOR) begin
                    tipo          <= TIPO_ULA;
                    entradaA8Bits <= dados_a;
                    entradaB8Bits <= dados_b;
                    opCode        <= cmd_opCode;
                end else if (cmd_opCode == OP_LOAD) begin
                    tipo <= TIPO_LOAD;
                end else begin
                    tipo <= TIPO_ERRO;
                end
            end
            if (finaliza) begin
                unique case (tipo)
                    TIPO_ULA: begin
                        res_dados  <= saida9Bits;
                        flag_carry <= saida9Bits[LARGURA];
                        res_erro   <= 1'b0;
                    end
                    TIPO_LOAD: begin
                        res_dados <= {1'b0, imediato};
                        res_erro  <= 1'b0;
                    end
                    default: begin
                        res_dados <= '0;
                        res_erro  <= 1'b1;
                    end
                endcase
            end
        end
    end

endmodule

// File: doc/ula_sequenciador.md
Name: ula_sequenciador

Overview:
Command sequencer and register bank that sits directly upstream of the 8-bit ALU (`ula`). It accepts one command at a time over a valid/ready handshake, reads two operands from a small register bank, and drives the ALU's A, B and opCode inputs. One clock later it captures the ALU's registered 9-bit result and writes the low 8 bits back to a destination register. It also latches bit 8 as the carry flag and reports the result on a one-cycle strobe.

Parameters:
NUM_REGS, 4, number of 8-bit general registers (power of two, minimum 2)
END_W, 2, register address width (equals log2 of NUM_REGS)

Ports:
clock  input  1  single system clock, rising edge
reset_n  input  1  asynchronous, active-low reset
cmd_valid  input  1  command present
cmd_ready  output  1  sequencer can accept a command
cmd_opCode  input  4  ALU opcode 0..11; 12 means LOAD immediate; 13..15 are illegal
cmd_fonteA  input  END_W  source register for operand A
cmd_fonteB  input  END_W  source register for operand B
cmd_destino  input  END_W  destination register
cmd_imediato  input  8  immediate value used by LOAD
entradaA8Bits  output  8  operand A to the ALU
entradaB8Bits  output  8  operand B to the ALU
opCode  output  4  opcode to the ALU
saida9Bits  input  9  registered result from the ALU
res_valid  output  1  one-cycle strobe: a command has completed
res_dados  output  9  completed result
res_erro  output  1  qualifies res_valid: command had an illegal opcode
flag_carry  output  1  bit 8 of the last successful ALU result
leitura_end  input  END_W  debug read address
leitura_dados  output  8  combinational read of register leitura_end

Behaviour:
- States: OCIOSO, EXECUTA, ESCREVE.
- cmd_ready = (estado == OCIOSO). It is combinational and reads 1 while in reset.
- Reset (asynchronous, reset_n = 0) clears:
  - state to OCIOSO;
  - all registers, entradaA8Bits, entradaB8Bits, opCode, res_dados and flag_carry to 0;
  - res_valid and res_erro to 0.
- Reset mid-operation aborts the command: no write-back and no res_valid.
- OCIOSO, on cmd_valid & cmd_ready (edge t0):
  - Opcode 0..11:
    - latch entradaA8Bits <= reg[cmd_fonteA], entradaB8Bits <= reg[cmd_fonteB];
    - latch opCode <= cmd_opCode and latch cmd_destino;
    - go to EXECUTA.
  - Opcode 12 (LOAD): latch cmd_imediato and cmd_destino; go to ESCREVE.
  - Opcode 13..15: go to ESCREVE with an error mark; the ALU is not used.
- EXECUTA: the ALU inputs are stable for the whole cycle. The ALU registers its result at edge t1. Go to ESCREVE.
- ESCREVE, at edge t2:
  - ALU command:
    - reg[dest] <= saida9Bits[7:0];
    - flag_carry <= saida9Bits[8];
    - res_dados <= saida9Bits;
    - res_erro <= 0.
  - LOAD:
    - reg[dest] <= imm;
    - res_dados <= {1'b0, imm};
    - flag_carry unchanged.
  - Illegal opcode:
    - no register write;
    - res_dados <= 9'h000;
    - res_erro <= 1;
    - flag_carry unchanged.
  - In every case: res_valid <= 1 for exactly one cycle, then go to OCIOSO.
- Latency, accept edge to res_valid high: ALU command 3 edges (t0 to t2, strobe visible after t2); LOAD and illegal 2 edges.
- Throughput: one ALU command per 3 cycles.
- Back-to-back: a new command may be accepted in the same cycle that res_valid is high.
- No data hazard exists, because the write completes before OCIOSO is re-entered. Any fonte may equal any destino.
- Comparison opcodes (2..6) return 9'h000 or 9'h001. Their bit 8 is 0, so they clear flag_carry.
- Subtraction borrow appears in saida9Bits[8] and is recorded in flag_carry as-is.
- cmd_* inputs are ignored unless the handshake fires. A cmd_valid held high with no ready edge has no effect.
- Register addresses wrap modulo NUM_REGS: only END_W bits are used.

Decomposition:
- Shared package `ula_pkg`:
  - opcode constants OP_SOMA=0 … OP_XNOR=11, OP_LOAD=12;
  - state encoding OCIOSO/EXECUTA/ESCREVE;
  - LARGURA=8.
- Natural sub-module: `banco_registradores`.
  - Two combinational read ports plus the debug port.
  - One synchronous write port.
  - Asynchronous active-low clear.
- The sequencer instantiates the bank alongside the `ula` at the top level. This block does not instantiate the `ula`.

Test Plan:
- LOAD r0=200, LOAD r1=100, then SOMA r2=r0+r1 → res_dados=9'h12C, flag_carry=1, leitura r2=8'h2C; res_valid exactly 3 edges after the SOMA accept.
- LOAD r0=5, r1=9, SUB r3=r0−r1 → res_dados=ALU result with bit8 borrow=1, r3=8'hFC; then MAIOR r2=(r1>r0) → res_dados=9'h001, flag_carry=0.
- Illegal opcode 14 with dest r0 (r0=0x55) → res_valid=1, res_erro=1, res_dados=0, r0 still 0x55, flag_carry unchanged.
- cmd_valid held high continuously with 4 LOADs → cmd_ready low in ESCREVE; one accept every 2 cycles; all 4 registers written in order; no command lost or duplicated.
- reset_n pulsed low during EXECUTA of SOMA r3 → no res_valid; all regs and outputs 0 immediately (asynchronous); cmd_ready=1 after release.
- Self-source: LOAD r1=0x0F, AND r1=r1&r1 (op 8) → r1=0x0F, res_dados=9'h00F, no hazard.
